// File: rtl/rf_entry_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_entry_ctrl_if
// Bundle between the keypad decoder, the entry controller and the operand
// register file / ALU.
//
// Handshake: key_valid is a valid-only, one-cycle pulse with no ready. A key
// is consumed on the CLK edge where key_valid=1 and the controller can use
// it. Keys the controller cannot use in its current state are dropped, never
// held or queued, so the keypad side must not wait for acknowledgement.
//
// Signals:
//   key_valid, key_code : keypad -> controller
//   level, Din, WE, W1  : controller -> register file write side
//   op, alu_start       : controller -> ALU
//   busy                : controller status (B write through alu_start)
//
// Modports:
//   master : the controller's view (drives the register-file/ALU side)
//   slave  : the environment's view (drives the keys)
// ---------------------------------------------------------------------------
interface rf_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       level;
  logic [3:0] Din;
  logic       WE;
  logic       W1;
  logic [1:0] op;
  logic       alu_start;
  logic       busy;

  modport master (
    input  key_valid, key_code,
    output level, Din, WE, W1, op, alu_start, busy
  );

  modport slave (
    output key_valid, key_code,
    input  level, Din, WE, W1, op, alu_start, busy
  );
endinterface

// File: rtl/rf_entry_ctrl.sv
// ---------------------------------------------------------------------------
// rf_entry_ctrl
// Sequencer between the keypad decoder and the two-entry operand register
// file. Collects two-digit operands A and B (tens then ones), commits each
// with ENTER as a one-cycle write pulse, latches the operator between them,
// then waits for the register-file read path to settle before issuing a
// one-cycle alu_start.
//
// Ports:
//   CLK          : system clock, all logic on posedge
//   RST          : synchronous active-high reset
//   bus          : rf_entry_ctrl_if.master (keys in; level/Din/WE/W1/op/
//                  alu_start/busy out, all registered)
//   o_dbg_state  : current FSM state, for observation only
// ---------------------------------------------------------------------------
module rf_entry_ctrl #(
  parameter logic [3:0]  KEY_ENTER     = 4'hE,
  parameter logic [3:0]  KEY_CLEAR     = 4'hF,
  parameter int unsigned SETTLE_CYCLES = 2    // legal 2..15
) (
  input  logic                  CLK,
  input  logic                  RST,
  rf_entry_ctrl_if.master       bus,
  output logic [3:0]            o_dbg_state
);

  typedef enum logic [3:0] {
    S_A_TENS  = 4'd0,
    S_A_ONES  = 4'd1,
    S_A_ENT   = 4'd2,
    S_A_WR    = 4'd3,
    S_OP_WAIT = 4'd4,
    S_B_TENS  = 4'd5,
    S_B_ONES  = 4'd6,
    S_B_ENT   = 4'd7,
    S_B_WR    = 4'd8,
    S_SETTLE  = 4'd9,
    S_GO      = 4'd10,
    S_RESULT  = 4'd11
  } state_t;

  // SETTLE occupies SETTLE_CYCLES-1 cycles; the counter runs 0..SETTLE_LAST.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 2);

  state_t     r_state;
  logic       r_level;
  logic [3:0] r_din;
  logic       r_we;
  logic       r_w1;
  logic [1:0] r_op;
  logic       r_alu_start;
  logic       r_busy;
  logic [3:0] r_cnt;

  // Key decode. CLEAR wins over ENTER, which wins over digit/operator, so
  // that a remapped KEY_ENTER/KEY_CLEAR never double-decodes.
  logic w_clear;
  logic w_enter;
  logic w_digit;
  logic w_oper;
  logic w_locked;

  assign w_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign w_enter = bus.key_valid && !w_clear && (bus.key_code == KEY_ENTER);
  assign w_digit = bus.key_valid && !w_clear && !w_enter &&
                   (bus.key_code <= 4'd9);
  assign w_oper  = bus.key_valid && !w_clear && !w_enter &&
                   (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);

  // Write cycles and the settle/go window ignore every key, CLEAR included:
  // the register file must see a clean write and the ALU a single start.
  assign w_locked = (r_state == S_A_WR) || (r_state == S_B_WR) ||
                    (r_state == S_SETTLE) || (r_state == S_GO);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_A_TENS;
      r_level     <= 1'b1;
      r_din       <= 4'd0;
      r_we        <= 1'b0;
      r_w1        <= 1'b0;
      r_op        <= 2'd0;
      r_alu_start <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      r_we        <= 1'b0;
      r_alu_start <= 1'b0;
      if (w_clear && !w_locked) begin
        // Din and op are kept; register-file contents are untouched.
        r_state <= S_A_TENS;
        r_level <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_A_TENS: if (w_digit) begin
            r_din   <= bus.key_code;
            r_level <= 1'b1;
            r_state <= S_A_ONES;
          end
          S_A_ONES: if (w_digit) begin
            r_din   <= bus.key_code;
            r_level <= 1'b0;
            r_state <= S_A_ENT;
          end
          S_A_ENT: if (w_enter) begin
            // Din/level were last changed by the ones digit at least one
            // edge earlier, so they are stable across the write pulse.
            r_we    <= 1'b1;
            r_w1    <= 1'b0;
            r_state <= S_A_WR;
          end
          S_A_WR: r_state <= S_OP_WAIT;
          S_OP_WAIT: if (w_oper) begin
            // A/B/C/D have low bits 10/11/00/01; adding 2 maps them to 0..3.
            r_op    <= bus.key_code[1:0] + 2'd2;
            r_state <= S_B_TENS;
          end
          S_B_TENS: if (w_digit) begin
            r_din   <= bus.key_code;
            r_level <= 1'b1;
            r_state <= S_B_ONES;
          end
          S_B_ONES: if (w_digit) begin
            r_din   <= bus.key_code;
            r_level <= 1'b0;
            r_state <= S_B_ENT;
          end
          S_B_ENT: if (w_enter) begin
            r_we    <= 1'b1;
            r_w1    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_B_WR;
          end
          S_B_WR: begin
            r_cnt   <= 4'd0;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt       <= 4'd0;
              r_alu_start <= 1'b1;
              r_state     <= S_GO;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_GO: begin
            r_busy  <= 1'b0;
            r_state <= S_RESULT;
          end
          S_RESULT: if (w_digit) begin
            // A digit here starts a fresh operand A as its tens digit.
            r_din   <= bus.key_code;
            r_level <= 1'b1;
            r_state <= S_A_ONES;
          end
          default: r_state <= S_A_TENS;
        endcase
      end
    end
  end

  assign bus.level     = r_level;
  assign bus.Din       = r_din;
  assign bus.WE        = r_we;
  assign bus.W1        = r_w1;
  assign bus.op        = r_op;
  assign bus.alu_start = r_alu_start;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rf_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_entry_ctrl
// Drives key pulses into two controllers (SETTLE_CYCLES = 2 and 4) and
// checks writes and ALU starts against a keypad-level reference model.
// A small register-file model turns level/Din/WE/W1 into stored operands.
// ---------------------------------------------------------------------------
module tb_rf_entry_ctrl;

  localparam int S = 2;

  logic       CLK;
  logic       RST;
  logic [3:0] dbg;
  logic [3:0] dbg4;

  rf_entry_ctrl_if kif ();
  rf_entry_ctrl_if kif4 ();

  assign kif4.key_valid = kif.key_valid;
  assign kif4.key_code  = kif.key_code;

  rf_entry_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .bus(kif.master), .o_dbg_state(dbg)
  );

  rf_entry_ctrl #(.SETTLE_CYCLES(4)) dut4 (
    .CLK(CLK), .RST(RST), .bus(kif4.master), .o_dbg_state(dbg4)
  );

  // ---------------- clock / reset / edge counter ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_edges = 0;
  always @(posedge CLK) n_edges <= n_edges + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- register-file model ----------------
  int rf_tens = 0;
  int rf_mem [2] = '{0, 0};
  always @(posedge CLK) begin
    if (kif.WE) rf_mem[kif.W1] <= rf_tens * 10 + int'(kif.Din);
    else if (kif.level) rf_tens <= int'(kif.Din);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_alu;
    logic [31:0] idx;
    logic        w1;
    logic [6:0]  val;
    logic [1:0]  op;
    logic [6:0]  a;
    logic [6:0]  b;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, req, n_edges);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = entering A, 1 = waiting operator, 2 = entering B, 3 = result
  int phase       = 0;
  int digs[$];
  int m_op        = 0;
  int m_a         = 0;
  int m_b         = 0;
  int block_until = 0;
  int busy_lo     = 1;
  int busy_hi     = 0;

  task automatic model_reset();
    phase       = 0;
    digs.delete();
    m_op        = 0;
    block_until = 0;
    busy_lo     = 1;
    busy_hi     = 0;
    exp_q.delete();
  endtask

  // Key c is sampled at edge e; events are indexed by the edge after which
  // the output is visible.
  task automatic model_key(input logic [3:0] c, input int e);
    ev_t ev;
    int  val;
    if (e <= block_until) return;
    if (c == 4'hF) begin
      phase = 0;
      digs.delete();
    end else if (c <= 4'd9) begin
      if ((phase == 0 || phase == 2) && digs.size() < 2) digs.push_back(int'(c));
      else if (phase == 3) begin
        phase = 0;
        digs.delete();
        digs.push_back(int'(c));
      end
    end else if (c >= 4'hA && c <= 4'hD) begin
      if (phase == 1) begin
        m_op  = int'(c) - 10;
        phase = 2;
        digs.delete();
      end
    end else if (c == 4'hE) begin
      if ((phase == 0 || phase == 2) && digs.size() == 2) begin
        val    = digs[0] * 10 + digs[1];
        ev     = '0;
        ev.idx = e;
        ev.w1  = (phase == 2);
        ev.val = 7'(val);
        exp_q.push_back(ev);
        if (phase == 0) begin
          m_a         = val;
          phase       = 1;
          block_until = e + 1;
        end else begin
          m_b         = val;
          ev          = '0;
          ev.is_alu   = 1'b1;
          ev.idx      = e + S;
          ev.op       = 2'(m_op);
          ev.a        = 7'(m_a);
          ev.b        = 7'(m_b);
          exp_q.push_back(ev);
          busy_lo     = e;
          busy_hi     = e + S;
          block_until = e + S + 1;
          phase       = 3;
        end
        digs.delete();
      end
    end
  endtask

  // ---------------- monitor ----------------
  int   prev_din = 0;
  ev_t  got;
  always @(negedge CLK) begin
    if (!RST) begin
      while (exp_q.size() > 0 && int'(exp_q[0].idx) < n_edges) begin
        got = exp_q.pop_front();
        chk(got.is_alu ? "missed_alu_start" : "missed_we", 0, 1);
      end
      if (kif.WE || kif.alu_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          got = exp_q.pop_front();
          if (got.is_alu) begin
            chk("alu_cycle", n_edges, int'(got.idx));
            chk("alu_pulse", int'(kif.alu_start), 1);
            chk("alu_op", int'(kif.op), int'(got.op));
            chk("dout_1", rf_mem[0], int'(got.a));
            chk("dout_2", rf_mem[1], int'(got.b));
          end else begin
            chk("we_cycle", n_edges, int'(got.idx));
            chk("we_pulse", int'(kif.WE), 1);
            chk("we_w1", int'(kif.W1), int'(got.w1));
            chk("we_value", rf_tens * 10 + int'(kif.Din), int'(got.val));
            chk("we_level", int'(kif.level), 0);
            chk("din_stable", int'(kif.Din), prev_din);
          end
        end
      end
      chk("busy", int'(kif.busy), int'(n_edges >= busy_lo && n_edges <= busy_hi));
    end
    prev_din = int'(kif.Din);
  end

  // Second instance: alu_start must trail its B write by exactly 4 edges.
  int w4       = -100;
  int alu4_cnt = 0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (kif4.WE && kif4.W1) w4 = n_edges;
      if (kif4.alu_start) begin
        chk("alu_start_s4", n_edges - w4, 4);
        alu4_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [3:0] c, input int gap);
    @(negedge CLK);
    kif.key_valid = 1'b1;
    kif.key_code  = c;
    model_key(c, n_edges + 1);
    repeat (gap) begin
      @(negedge CLK);
      kif.key_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      kif.key_valid = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"}, int'(kif.level), 1);
    chk({tag, "_din"}, int'(kif.Din), 0);
    chk({tag, "_we"}, int'(kif.WE), 0);
    chk({tag, "_w1"}, int'(kif.W1), 0);
    chk({tag, "_op"}, int'(kif.op), 0);
    chk({tag, "_alu_start"}, int'(kif.alu_start), 0);
    chk({tag, "_busy"}, int'(kif.busy), 0);
    chk({tag, "_state"}, int'(dbg), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST           = 1'b1;
    kif.key_valid = 1'b0;
    model_reset();
    @(negedge CLK);
    check_reset_vals(tag);
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int r;
  logic [3:0] kc;

  initial begin
    RST           = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    repeat (3) @(negedge CLK);
    check_reset_vals("por");
    RST = 1'b0;

    // Reset mid-entry after A tens digit 7.
    send_key(4'd7, 2);
    do_reset("mid_reset");

    // 42 A 15 with idle gaps.
    send_key(4'd4, 3); send_key(4'd2, 3); send_key(4'hE, 3);
    send_key(4'hA, 3); send_key(4'd1, 3); send_key(4'd5, 3);
    send_key(4'hE, 3);
    idle(8);

    // New entry from RESULT; ENTER after one digit is ignored.
    send_key(4'd9, 2); send_key(4'hE, 2); send_key(4'd3, 2);
    send_key(4'hE, 3);

    // Clear, stray operator/ENTER in A_TENS, digits in OP_WAIT, then D.
    send_key(4'hF, 2);
    send_key(4'hB, 1); send_key(4'hE, 1); send_key(4'hC, 1);
    send_key(4'd5, 1); send_key(4'd5, 1); send_key(4'hE, 3);
    send_key(4'd1, 1); send_key(4'd7, 1); send_key(4'hE, 1);
    send_key(4'hD, 2);
    send_key(4'd2, 1); send_key(4'd0, 1); send_key(4'hE, 1);
    idle(8);

    // Clear during B entry leaves operand B untouched.
    send_key(4'hF, 1);
    send_key(4'd1, 1); send_key(4'd2, 1); send_key(4'hE, 2);
    send_key(4'hB, 1); send_key(4'd3, 1); send_key(4'hF, 1);
    idle(4);
    chk("dout_2_kept", rf_mem[1], m_b);

    // Keys during the write/settle/go window are dropped.
    send_key(4'd6, 1); send_key(4'd1, 1); send_key(4'hE, 2);
    send_key(4'hC, 1); send_key(4'd0, 1); send_key(4'd9, 2);
    send_key(4'hE, 0);
    send_key(4'd4, 0); send_key(4'd4, 0); send_key(4'd4, 0);
    idle(8);

    // Back-to-back keys.
    send_key(4'hF, 1);
    send_key(4'd8, 0); send_key(4'd6, 0); send_key(4'hE, 0);
    idle(2);
    send_key(4'hA, 1);
    send_key(4'd3, 0); send_key(4'd3, 0); send_key(4'hE, 0);
    idle(10);

    // Randomized keys, weighted toward completing sequences.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      kc = 4'($urandom_range(0, 9));
      else if (r < 68) kc = 4'hE;
      else if (r < 85) kc = 4'($urandom_range(10, 13));
      else if (r < 90) kc = 4'hF;
      else             kc = 4'($urandom_range(0, 15));
      send_key(kc, $urandom_range(0, 3));
    end
    idle(12);

    chk("queue_drained", exp_q.size(), 0);
    chk("s4_alu_seen", int'(alu4_cnt > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_entry_ctrl.md
Name: rf_entry_ctrl

Overview:
Sequencer between the keypad decoder and the two-entry operand register file.
- Turns a stream of key pulses into two-digit operands and drives the register file's digit-select (level), data (Din), write-enable (WE) and write address (W1).
- After both operands are committed, waits for the register-file read path to settle, then issues a one-cycle start pulse with the latched operator to the ALU.

Parameters:
KEY_ENTER, 4'hE, key code that commits the current operand
KEY_CLEAR, 4'hF, key code that aborts entry and returns to operand A
SETTLE_CYCLES, 2, cycles between the operand-B write pulse and alu_start; legal range 2..15

Ports:
CLK  input  1  system clock, all logic on posedge
RST  input  1  synchronous active-high reset
key_valid  input  1  one-cycle pulse; key_code valid this cycle
key_code  input  4  0-9 digit, A-D operator (add, sub, mul, div), E enter, F clear
level  output  1  register-file digit select: 1 = tens, 0 = ones
Din  output  4  digit value to the register file
WE  output  1  register-file write enable, one-cycle pulse
W1  output  1  register-file write address: 0 = operand A, 1 = operand B
op  output  2  latched operator (A→0, B→1, C→2, D→3)
alu_start  output  1  one-cycle pulse; Dout_1/Dout_2 and op are valid
busy  output  1  high from the operand-B write until the alu_start pulse, inclusive

Behaviour:
- All outputs are registered. Keys accepted on the CLK edge where key_valid=1; outputs change on that edge.
- Reset (RST=1 at a posedge) takes priority over everything, including a mid-sequence or WE cycle. Reset values: state=A_TENS, level=1, Din=0, WE=0, W1=0, op=0, alu_start=0, busy=0, settle counter=0.
- States and transitions:
  - A_TENS: digit → Din=digit, level=1 → A_ONES.
  - A_ONES: digit → Din=digit, level=0 → A_ENT.
  - A_ENT: KEY_ENTER → WE=1, W1=0 for exactly one cycle (A_WR) → OP_WAIT.
  - OP_WAIT: key A-D → op latched → B_TENS.
  - B_TENS, B_ONES, B_ENT: same as the A states. B_WR pulses WE=1 with W1=1, then goes to SETTLE.
  - SETTLE: counts SETTLE_CYCLES-1 cycles after the B_WR cycle, then → GO.
  - GO: alu_start=1 for one cycle → RESULT.
  - RESULT: holds until KEY_CLEAR. A digit key here also starts a new entry: it is treated as the A tens digit and the FSM moves to A_ONES.
- Level/Din stability: level and Din never change in the cycle WE=1, or the cycle before it, so the register file's combinational temp capture is stable at the write edge.
- Ignored keys (no state or output change):
  - digits in A_ENT, B_ENT, OP_WAIT, SETTLE, GO
  - operators in any state except OP_WAIT
  - KEY_ENTER in any state except A_ENT and B_ENT
  - any key while WE=1 or during SETTLE/GO; key_valid in these cycles is dropped, not queued.
- KEY_CLEAR from any state except SETTLE/GO:
  - next state A_TENS, level=1, WE=0, busy=0
  - op and Din keep their values
  - register-file contents are not erased.
- Latency: enter key edge → WE high at the next edge, for one cycle. B write edge → alu_start exactly SETTLE_CYCLES edges later.
- Operand value written = tens*10 + ones, computed by the register file. The controller performs no arithmetic and no range check beyond key decoding.

Test Plan:
1. Reset mid-entry (after A tens digit 7) → next cycle level=1, Din=0, WE=0, W1=0, alu_start=0, state A_TENS.
2. Keys 4,2,E,A,1,5,E with 3 idle cycles between keys → one WE pulse with W1=0 while level=0/Din=2, one WE pulse with W1=1 while Din=5; alu_start pulses exactly 2 cycles after the second WE; op=0; register-file Dout_1=42, Dout_2=15 at alu_start.
3. Keys 9,E (enter after one digit) → enter ignored, no WE. Then 3,E → WE with operand 93.
4. Operator or E keys in A_TENS, and digit keys in OP_WAIT → no WE, state unchanged; then D accepted in OP_WAIT → op=3.
5. Keys 1,2,E,B,3,F → returns to A_TENS with no W1=1 write; Dout_2 unchanged. A key pressed during SETTLE is dropped and alu_start still fires once.
6. Back-to-back key_valid pulses on consecutive cycles (8,6,E) → exactly one A write of 86. With SETTLE_CYCLES=4 in a second run → alu_start 4 cycles after the B write.
